fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle/pipelined RISC-V core.
- Owns the program counter and drives the byte address into the instruction memory, which returns a combinational 32-bit word.
- Registers {pc, instruction} into a one-entry IF output buffer that feeds decode through a valid/ready handshake.
- Handles branch/jump redirects and halt-on-ECALL/EBREAK, and flags misaligned or out-of-range fetch addresses.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MEM_BYTES, 4096, instruction memory size in bytes; valid fetch iff pc + 3 < MEM_BYTES.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- imem_addr  output  16  byte address to instruction memory; equals pc register.
- imem_data  input  32  instruction word from memory, combinational on imem_addr; passed through unmodified.
- redirect_valid  input  1  branch/jump taken; load redirect_target.
- redirect_target  input  16  new PC byte address.
- if_valid  output  1  IF buffer holds a valid instruction.
- if_ready  input  1  decode accepts the IF buffer this cycle.
- if_inst  output  32  buffered instruction.
- if_pc  output  16  PC of the buffered instruction.
- halted  output  1  ECALL/EBREAK fetched; fetch stopped.
- fault  output  1  misaligned or out-of-range fetch; fetch stopped.
- fetch_count  output  32  number of instructions loaded into the IF buffer.

Behaviour:
- Reset (rst_n=0 at a clock edge), regardless of state or pending transfers:
  - pc=RESET_PC; state=RUN; if_valid=0; if_inst=32'h00000013 (NOP); if_pc=RESET_PC.
  - halted=0; fault=0; fetch_count=0.
- imem_addr = pc at all times (combinational from register).
- States:
  - RUN: fetching.
  - HALT: ECALL/EBREAK seen.
  - FAULT: bad address.
- load = (state==RUN) && addr_ok(pc) && (!if_valid || if_ready) && !redirect_valid
  - addr_ok(a) = (a[1:0]==0) && (a+3 < MEM_BYTES), evaluated at 17-bit width.
- On load:
  - if_inst<=imem_data; if_pc<=pc; if_valid<=1; pc<=pc+4, wrapping modulo 2^16.
  - fetch_count<=fetch_count+1, wrapping at 2^32.
- Accept without load: if_valid && if_ready && !load clears if_valid.
- No new word and no accept: if_valid, if_inst and if_pc hold their values. Decode may sample them while if_valid=1.
- Redirect (highest priority after reset):
  - pc<=redirect_target; if_valid<=0 (flush buffered instruction); no load that cycle.
  - First instruction at the target is loaded the following cycle, provided the buffer is free.
  - Redirect is honoured in RUN and HALT: it returns HALT to RUN and clears halted, for trap/return handling.
  - In FAULT, only reset exits.
- Halt:
  - On load of 32'h00000073 (ECALL) or 32'h00100073 (EBREAK), the word is still loaded normally.
  - Next cycle: state=HALT, halted=1, pc stops advancing.
  - The buffered ECALL/EBREAK remains deliverable to decode.
- Fault:
  - In RUN, if !addr_ok(pc) and no redirect this cycle: state<=FAULT, fault<=1.
  - No load occurs; the existing buffer content may still drain.
  - pc freezes at the offending value.
- Simultaneous events:
  - redirect_valid and if_ready in the same cycle: redirect wins; buffer flushed.
  - if_ready with if_valid=0: ignored.
- Latency: pc to if_valid is 1 cycle. Steady-state throughput is one instruction per cycle while if_ready=1.
- Stall: if_valid=1 and if_ready=0 hold pc and the buffer stable, so no instruction is dropped or duplicated.

Test Plan:
- Reset and stream:
  - Stimulus: mem holds words W0..W3 at addresses 0,4,8,12; if_ready=1; release rst_n.
  - Response: if_pc=0,4,8,12 on consecutive cycles with if_inst=W0..W3; fetch_count=4.
- Backpressure:
  - Stimulus: hold if_ready=0 for 3 cycles after the first word.
  - Response: if_pc=0 and if_inst=W0 stay stable; pc stays 4; after release, words 4 and 8 arrive in order with no gaps or duplicates.
- Redirect:
  - Stimulus: redirect_valid=1 with target 16'h0040 while if_valid=1 (if_pc=8), with if_ready=1 in the same cycle.
  - Response: if_valid=0 the next cycle; then if_pc=16'h0040; word 8 is never delivered.
- Halt:
  - Stimulus: place 32'h00000073 at address 16.
  - Response: it is delivered with if_pc=16; halted=1; no fetch from address 20.
  - Follow-up: redirect to 0 clears halted and resumes fetch at 0.
- Faults:
  - Stimulus 1: redirect to 16'h0006. Response: fault=1; no further loads.
  - Stimulus 2 (after reset): redirect to 16'h0FFC. Response: word at 0xFFC is fetched; then pc=0x1000 sets fault=1.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one cycle while if_valid=1 and in HALT.
  - Response: all outputs at reset values the next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction memory, redirect and IF buffer signals
// Purpose: bundles every non-clock/reset signal of fetch_unit.
// Ports (master = fetch_unit side):
//   imem_addr       out 16  byte address to instruction memory
//   imem_data       in  32  combinational instruction word
//   redirect_valid  in  1   branch/jump taken
//   redirect_target in  16  new PC byte address
//   if_valid        out 1   IF buffer holds an instruction
//   if_ready        in  1   decode accepts the IF buffer
//   if_inst         out 32  buffered instruction
//   if_pc           out 16  PC of buffered instruction
//   halted          out 1   ECALL/EBREAK fetched
//   fault           out 1   bad fetch address seen
//   fetch_count     out 32  instructions loaded into the buffer
interface fetch_unit_if;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [15:0] if_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_target,
    output if_valid,
    input  if_ready,
    output if_inst,
    output if_pc,
    output halted,
    output fault,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_target,
    input  if_valid,
    output if_ready,
    input  if_inst,
    input  if_pc,
    input  halted,
    input  fault,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RISC-V instruction fetch stage with one-entry IF output buffer
// Purpose: owns the PC, fetches from a combinational instruction memory into a
// valid/ready IF buffer, handles redirects, halts on ECALL/EBREAK and stops on
// misaligned or out-of-range fetch addresses.
// Ports:
//   clk    in  1  core clock, rising edge
//   rst_n  in  1  synchronous active-low reset
//   bus    fetch_unit_if.master  memory, redirect and IF buffer signals
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MEM_BYTES = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_e;

  localparam logic [16:0] MEM_LIMIT = 17'(MEM_BYTES);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] ECALL     = 32'h0000_0073;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic addr_ok;
  logic redirect_take;
  logic load;
  logic is_trap;

  // 17-bit compare so pc near 16'hFFFF cannot wrap back into range.
  assign addr_ok = (pc_q[1:0] == 2'b00) && (({1'b0, pc_q} + 17'd3) < MEM_LIMIT);
  // Only reset leaves FAULT, so a redirect there is ignored entirely.
  assign redirect_take = bus.redirect_valid && (state_q != ST_FAULT);
  assign load = (state_q == ST_RUN) && addr_ok && (!if_valid_q || bus.if_ready)
                && !bus.redirect_valid;
  assign is_trap = (bus.imem_data == ECALL) || (bus.imem_data == EBREAK);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_inst_d     = if_inst_q;
    if_pc_d       = if_pc_q;
    fetch_count_d = fetch_count_q;

    if (redirect_take) begin
      pc_d       = bus.redirect_target;
      if_valid_d = 1'b0;
      state_d    = ST_RUN;
    end else if (load) begin
      if_inst_d     = bus.imem_data;
      if_pc_d       = pc_q;
      if_valid_d    = 1'b1;
      pc_d          = pc_q + 16'd4;
      fetch_count_d = fetch_count_q + 32'd1;
      if (is_trap) begin
        state_d = ST_HALT;
      end
    end else begin
      if (if_valid_q && bus.if_ready) begin
        if_valid_d = 1'b0;
      end
      if ((state_q == ST_RUN) && !addr_ok) begin
        state_d = ST_FAULT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_inst_q     <= NOP;
      if_pc_q       <= RESET_PC;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_inst_q     <= if_inst_d;
      if_pc_q       <= if_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_inst     = if_inst_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.fault       = (state_q == ST_FAULT);
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] mem [0:1023];

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (16'h0000),
    .MEM_BYTES(4096)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.imem_data = (bus.imem_addr < 16'h1000) ? mem[bus.imem_addr[11:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic buf_is(input string tag, input logic v, input logic [15:0] pc,
                        input logic [31:0] inst);
    check({tag, "_valid"}, {31'd0, bus.if_valid}, {31'd0, v});
    if (v) begin
      check({tag, "_pc"}, {16'd0, bus.if_pc}, {16'd0, pc});
      check({tag, "_inst"}, bus.if_inst, inst);
    end
  endtask

  task automatic redirect(input logic [15:0] tgt);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = tgt;
    step();
    bus.redirect_valid  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem[4]     = 32'h0000_0073;
    mem[10'h3FF] = 32'hBEEF_0FFC;
    bus.if_ready        = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 16'h0;

    // Reset state, then a four-word stream.
    do_reset();
    check("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    check("rst_inst", bus.if_inst, 32'h0000_0013);
    check("rst_pc", {16'd0, bus.if_pc}, 32'd0);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    check("rst_fault", {31'd0, bus.fault}, 32'd0);
    check("rst_count", bus.fetch_count, 32'd0);
    check("rst_addr", {16'd0, bus.imem_addr}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      buf_is($sformatf("stream%0d", k), 1'b1, 16'(4 * k), 32'hA000_0000 | k);
    end
    check("stream_count", bus.fetch_count, 32'd4);

    // Backpressure after the first word.
    do_reset();
    step();
    buf_is("bp_first", 1'b1, 16'h0, 32'hA000_0000);
    bus.if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      buf_is($sformatf("bp_hold%0d", k), 1'b1, 16'h0, 32'hA000_0000);
      check("bp_pc", {16'd0, bus.imem_addr}, 32'd4);
    end
    check("bp_count", bus.fetch_count, 32'd1);
    bus.if_ready = 1'b1;
    step();
    buf_is("bp_w1", 1'b1, 16'h4, 32'hA000_0001);
    step();
    buf_is("bp_w2", 1'b1, 16'h8, 32'hA000_0002);
    check("bp_count2", bus.fetch_count, 32'd3);

    // Redirect while if_pc=8 is buffered and decode is ready.
    redirect(16'h0040);
    check("rd_flush", {31'd0, bus.if_valid}, 32'd0);
    check("rd_addr", {16'd0, bus.imem_addr}, 32'h40);
    step();
    buf_is("rd_target", 1'b1, 16'h40, 32'hA000_0010);
    check("rd_count", bus.fetch_count, 32'd4);

    // Halt on ECALL at address 16.
    redirect(16'h000C);
    check("h_flush", {31'd0, bus.if_valid}, 32'd0);
    step();
    buf_is("h_w3", 1'b1, 16'hC, 32'hA000_0003);
    step();
    buf_is("h_ecall", 1'b1, 16'h10, 32'h0000_0073);
    check("h_halted", {31'd0, bus.halted}, 32'd1);
    step();
    check("h_drained", {31'd0, bus.if_valid}, 32'd0);
    step();
    check("h_nofetch", {31'd0, bus.if_valid}, 32'd0);
    check("h_count", bus.fetch_count, 32'd6);
    check("h_pc", {16'd0, bus.imem_addr}, 32'h14);
    redirect(16'h0000);
    check("h_resume_halted", {31'd0, bus.halted}, 32'd0);
    step();
    buf_is("h_resume", 1'b1, 16'h0, 32'hA000_0000);
    check("h_resume_count", bus.fetch_count, 32'd7);

    // Misaligned redirect faults; later redirects are ignored.
    redirect(16'h0006);
    check("f1_nofault_yet", {31'd0, bus.fault}, 32'd0);
    step();
    check("f1_fault", {31'd0, bus.fault}, 32'd1);
    check("f1_valid", {31'd0, bus.if_valid}, 32'd0);
    redirect(16'h0000);
    step();
    check("f1_stuck", {31'd0, bus.fault}, 32'd1);
    check("f1_pc", {16'd0, bus.imem_addr}, 32'h6);
    check("f1_count", bus.fetch_count, 32'd7);

    // Last in-range word is fetched, the next pc is out of range.
    do_reset();
    redirect(16'h0FFC);
    check("f2_valid0", {31'd0, bus.if_valid}, 32'd0);
    step();
    buf_is("f2_last", 1'b1, 16'h0FFC, 32'hBEEF_0FFC);
    check("f2_pc", {16'd0, bus.imem_addr}, 32'h1000);
    step();
    check("f2_fault", {31'd0, bus.fault}, 32'd1);
    check("f2_count", bus.fetch_count, 32'd1);
    check("f2_valid", {31'd0, bus.if_valid}, 32'd0);

    // Reset while halted with a buffered ECALL.
    do_reset();
    bus.if_ready = 1'b0;
    redirect(16'h0010);
    step();
    buf_is("mr_ecall", 1'b1, 16'h10, 32'h0000_0073);
    check("mr_halted", {31'd0, bus.halted}, 32'd1);
    do_reset();
    check("mr_valid", {31'd0, bus.if_valid}, 32'd0);
    check("mr_inst", bus.if_inst, 32'h0000_0013);
    check("mr_halted0", {31'd0, bus.halted}, 32'd0);
    check("mr_count", bus.fetch_count, 32'd0);
    check("mr_addr", {16'd0, bus.imem_addr}, 32'd0);
    step();
    buf_is("mr_restart", 1'b1, 16'h0, 32'hA000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
